// File: rtl/sbox_inverse.sv
// Inverse S-box builder: loads a forward permutation S (entry i = S[i]), builds INV[S[i]] = i, flags duplicates.
// Latency: lookups return INV[lk_in] one cycle after lk_valid, one per cycle; ready rises the cycle after the last load beat.
// Backpressure: load_ready is high only while loading and not clearing; lookups have no backpressure and are dropped outside DONE.
//
// Ports:
//   clk, rst (async active-low), clear (sync restart of the load phase)
//   load_valid/load_ready/load_data : forward S-box entries, in index order
//   ready, error, err_index         : table complete / duplicate seen (sticky) / index of the duplicate entry
//   lk_valid/lk_in -> lk_out_valid/lk_out : inverse lookup port
module sbox_inverse #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load_valid,
    input  logic [W-1:0] load_data,
    output logic         load_ready,
    output logic         ready,
    output logic         error,
    output logic [W:0]   err_index,
    input  logic         lk_valid,
    input  logic [W-1:0] lk_in,
    output logic         lk_out_valid,
    output logic [W-1:0] lk_out
);

    localparam int N = 1 << W;
    localparam logic [W:0] LAST_IDX = (W+1)'(N - 1);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_DONE = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t         state_q,        state_d;
    logic [W:0]     count_q,        count_d;
    logic [N-1:0]   written_q,      written_d;
    logic           ready_q,        ready_d;
    logic           error_q,        error_d;
    logic [W:0]     err_index_q,    err_index_d;
    logic           lk_out_valid_q, lk_out_valid_d;
    logic [W-1:0]   lk_out_q,       lk_out_d;

    // Inverse table. Not reset: contents are only meaningful once every
    // symbol has been written exactly once (state DONE).
    logic [W-1:0]   inv_mem [N];

    logic           load_acc;
    logic           dup;
    logic           wr_en;

    // Clear suppresses the handshake so a beat presented alongside clear
    // is never half-accepted.
    assign load_ready = (state_q == ST_LOAD) && !clear;
    assign load_acc   = load_valid && load_ready;
    assign dup        = written_q[load_data];
    assign wr_en      = load_acc && !dup;

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        written_d      = written_q;
        ready_d        = ready_q;
        error_d        = error_q;
        err_index_d    = err_index_q;
        lk_out_valid_d = 1'b0;
        lk_out_d       = lk_out_q;

        if (clear) begin
            // lk_out deliberately keeps its last value across a clear.
            state_d     = ST_LOAD;
            count_d     = '0;
            written_d   = '0;
            ready_d     = 1'b0;
            error_d     = 1'b0;
            err_index_d = '0;
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    if (load_acc) begin
                        if (dup) begin
                            // A duplicate on the last entry also lands here,
                            // never in DONE.
                            state_d     = ST_ERR;
                            error_d     = 1'b1;
                            err_index_d = count_q;
                        end else begin
                            written_d[load_data] = 1'b1;
                            count_d              = count_q + (W+1)'(1);
                            // N distinct W-bit symbols cover the whole domain,
                            // so reaching the last index means the table is full.
                            if (count_q == LAST_IDX) begin
                                state_d = ST_DONE;
                                ready_d = 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (lk_valid) begin
                        lk_out_valid_d = 1'b1;
                        lk_out_d       = inv_mem[lk_in];
                    end
                end
                ST_ERR: begin
                    // Sticky until clear or reset.
                end
                default: begin
                    state_d = ST_LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_LOAD;
            count_q        <= '0;
            written_q      <= '0;
            ready_q        <= 1'b0;
            error_q        <= 1'b0;
            err_index_q    <= '0;
            lk_out_valid_q <= 1'b0;
            lk_out_q       <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            written_q      <= written_d;
            ready_q        <= ready_d;
            error_q        <= error_d;
            err_index_q    <= err_index_d;
            lk_out_valid_q <= lk_out_valid_d;
            lk_out_q       <= lk_out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            inv_mem[load_data] <= count_q[W-1:0];
        end
    end

    assign ready        = ready_q;
    assign error        = error_q;
    assign err_index    = err_index_q;
    assign lk_out_valid = lk_out_valid_q;
    assign lk_out       = lk_out_q;

endmodule
